// File: rtl/sram_bus_pkg.sv
// -----------------------------------------------------------------------------
// sram_bus_pkg
// Shared types and defaults for the synchronous SRAM bus initiator.
//   state_t        : access-sequencer phase (IDLE -> SETUP -> PULSE -> HOLD)
//   DEF_*          : default bus widths and phase lengths (in clk cycles)
//   max3()         : helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package sram_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 11;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_bus_master.sv
// -----------------------------------------------------------------------------
// sram_bus_master
// Single-beat initiator for an asynchronous SRAM (active-low we_n / oe_n,
// shared bidirectional data). A request accepted in IDLE is sequenced through
// SETUP, PULSE and HOLD phases of programmable length, then answered with a
// one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_valid/req_ready   : request handshake; ready only while IDLE
//   req_write/addr/wdata  : request fields, sampled at acceptance only
//   rsp_valid/rsp_rdata   : completion pulse; rdata updated by reads only
//   sram_addr/data/we_n/oe_n : SRAM bus, all registered
// -----------------------------------------------------------------------------
module sram_bus_master
    import sram_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
        $error("sram_bus_master: SETUP/PULSE/HOLD_CYCLES must all be >= 1");
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_done;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drv_en;
    logic                  r_we_n;
    logic                  r_oe_n;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // One down-counter serves every phase: it is reloaded with (length-1)
    // on entry and the phase ends when it reaches zero.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                    w_cnt_next   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_PULSE;
                    w_cnt_next   = CNT_W'(PULSE_CYCLES - 1);
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = CNT_W'(HOLD_CYCLES - 1);
                    w_capture    = ~r_write;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they change
    // exactly on the phase boundary with no combinational glitches. PULSE is
    // only reachable from SETUP, by which time r_write is already latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_drv_en    <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_we_n      <= ~((w_state_next == ST_PULSE) &&  r_write);
            r_oe_n      <= ~((w_state_next == ST_PULSE) && !r_write);
            r_rsp_valid <= w_done;
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_drv_en <= req_write;
            end
            // Write data stays on the bus through HOLD: the SRAM commits on
            // the rising edge of we_n, one phase before this point.
            if (w_done) begin
                r_drv_en <= 1'b0;
            end
            if (w_capture) begin
                r_rdata <= sram_data;
            end
        end
    end

    assign sram_data = r_drv_en ? r_wdata : {DATA_WIDTH{1'bz}};
    assign sram_addr = r_addr;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule

// File: doc/sram_bus_master.md
Name: sram_bus_master

Overview:
Synchronous initiator for the asynchronous 2048x8 SRAM bus: active-low write enable, active-low output enable, bidirectional data. Accepts single-beat read/write requests from a clocked client (CPU bridge or voice engine) over a valid/ready handshake. Sequences address setup, strobe pulse and hold phases with cycle-programmable widths, then returns a one-cycle response. Sits between the synchronous core and the external or behavioural SRAM.

Parameters:
DATA_WIDTH, 8, SRAM data bus width
ADDR_WIDTH, 11, SRAM address width (2048 locations)
SETUP_CYCLES, 1, cycles address/data are stable before the strobe falls; must be >= 1
PULSE_CYCLES, 2, cycles the strobe (we_n or oe_n) is held low; must be >= 1
HOLD_CYCLES, 1, cycles address/write data are held after the strobe rises; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  client request present
req_ready  output  1  master idle and able to accept; high only in IDLE
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  target address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid after a read
sram_addr  output  ADDR_WIDTH  SRAM address bus
sram_data  inout  DATA_WIDTH  SRAM data bus; driven only during write phases, else high-Z
sram_we_n  output  1  SRAM write enable, low = write
sram_oe_n  output  1  SRAM output enable, low = drive

Behaviour:
- Reset (rst_n low, async): state IDLE; sram_we_n=1, sram_oe_n=1, sram_data high-Z, sram_addr=0, rsp_valid=0, rsp_rdata=0, counter=0; req_ready=1 once out of reset.
- FSM states: IDLE, SETUP, PULSE, HOLD. All bus outputs are registered (no glitches).
- IDLE: req_ready=1. On a rising edge with req_valid&req_ready, latch addr/wdata/write, drive sram_addr, and go to SETUP. For writes, begin driving sram_data the same edge.
- SETUP: we_n=1, oe_n=1. Stays SETUP_CYCLES cycles, then goes to PULSE.
- PULSE write: we_n=0, oe_n=1, data driven.
- PULSE read: oe_n=0, we_n=1, data high-Z.
- PULSE duration: PULSE_CYCLES cycles. For reads, sram_data is captured into rsp_rdata on the edge that ends PULSE.
- HOLD: we_n=1, oe_n=1. Address still held; write data still driven, because the SRAM commits on the rising edge of we_n. Stays HOLD_CYCLES cycles, then goes to IDLE.
- we_n and oe_n are never low simultaneously. oe_n stays high for the whole write access.
- Latency: with acceptance at edge 0, rsp_valid=1 in cycle SETUP+PULSE+HOLD+1 for exactly one cycle (defaults: cycle 5).
- rsp_valid coincides with IDLE and req_ready=1, so back-to-back acceptance is allowed in that cycle. Peak throughput is one access per S+P+H+1 cycles.
- After IDLE, sram_data returns to high-Z and sram_addr holds its last value.
- rsp_rdata holds its value until the next read completes; writes do not alter it.
- Busy: req_valid while req_ready=0 is ignored. The client must hold the request; no queueing.
- Request inputs are sampled only at acceptance. Later changes have no effect on the access in flight.
- Addresses are used as-is (ADDR_WIDTH bits); no wrap or range logic.
- Phase counter width: $clog2(max(S,P,H)+1). A parameter value < 1 is an elaboration-time error.
- Reset mid-operation: strobes go high and the bus goes high-Z immediately; no rsp_valid is issued. A reset during a write PULSE leaves the addressed location undefined (documented, not prevented). The client must reissue.

Decomposition:
- Package sram_bus_pkg:
  - state enum (IDLE, SETUP, PULSE, HOLD)
  - default timing constants
  - default DATA_WIDTH/ADDR_WIDTH
- No sub-module. The FSM and a single down-counter reloaded per phase fit in one module.
- The tri-state driver is a single continuous assignment gated by a registered drive-enable.

Test Plan:
- Reset: hold rst_n low mid-clock -> we_n=1, oe_n=1, sram_data=Z, rsp_valid=0, rsp_rdata=0x00 without waiting for a clock edge; req_ready=1 after release.
- Write 0x5A to 0x123, then read 0x123 (defaults) -> we_n low exactly 2 cycles with oe_n=1; oe_n low exactly 2 cycles on the read; rsp_valid in cycle 5 after each acceptance; rsp_rdata=0x5A.
- Back-to-back: req_valid held high with write 0x000<-0xA5, write 0x7FF<-0x3C, read 0x000, read 0x7FF -> each new request accepted in the prior rsp_valid cycle; reads return 0xA5 then 0x3C.
- Busy ignore: change req_addr/req_wdata during an in-flight write of 0x11 to 0x010 -> memory[0x010]=0x11; the changed request is accepted only once req_ready=1.
- Timing sweep S=2, P=4, H=3 -> strobe low 4 cycles; address stable 2 cycles before the strobe falls and 3 after it rises; rsp_valid in cycle 10.
- Reset during read PULSE -> oe_n rises asynchronously, no rsp_valid, rsp_rdata unchanged; next read of a known location returns correct data.
